// File: rtl/common_cnt_pkg.sv
// Shared definitions for the up/down counter bank family.
//   cnt_mode_e      : overflow behaviour (wrap-around or saturating)
//   CntWidthMin/Max : legal range of the counter width parameter
//   CntChanMin/Max  : legal range of the channel count parameter
package common_cnt_pkg;

  typedef enum logic {
    ModeWrap = 1'b0,
    ModeSat  = 1'b1
  } cnt_mode_e;

  localparam int CntWidthMin = 1;
  localparam int CntWidthMax = 32;
  localparam int CntChanMin  = 1;
  localparam int CntChanMax  = 32;

endpackage

// File: rtl/common_decinc_n.sv
// Combinational WIDTH-bit incrementer/decrementer.
//   d   : operand
//   dec : 1 = d - 1, 0 = d + 1
//   q   : result modulo 2^WIDTH
//   c   : carry out (increment of all-ones) or borrow out (decrement of zero)
module common_decinc_n #(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] d,
  input  logic             dec,
  output logic [WIDTH-1:0] q,
  output logic             c
);

  logic [WIDTH:0] ext;
  logic [WIDTH:0] res;

  // One extra bit catches the carry/borrow: it is set only when the
  // operation leaves the WIDTH-bit range.
  always_comb begin
    ext = {1'b0, d};
    if (dec) begin
      res = ext - {{WIDTH{1'b0}}, 1'b1};
    end else begin
      res = ext + {{WIDTH{1'b0}}, 1'b1};
    end
  end

  assign q = res[WIDTH-1:0];
  assign c = res[WIDTH];

endmodule

// File: rtl/common_udcnt_bank.sv
// Bank of CHANNELS independent up/down counters with load, carry/borrow pulses
// and a sticky overflow flag per channel.
//   clk, resetn   : clock, asynchronous active-low reset
//   i_inc/i_dec   : per-channel increment / decrement requests
//   i_load        : per-channel load (highest priority)
//   i_load_value  : load data, channel k at [k*WIDTH +: WIDTH]
//   i_ovf_clear   : per-channel clear of the sticky overflow flag
//   o_count       : registered counts, same packing as i_load_value
//   o_carry       : one-cycle pulse, increment attempted at all-ones
//   o_borrow      : one-cycle pulse, decrement attempted at zero
//   o_zero/o_full : count == 0 / count == all-ones
//   o_ovf_sticky  : set by any carry or borrow, held until cleared
module common_udcnt_bank
  import common_cnt_pkg::*;
#(
  parameter int               WIDTH       = 2,
  parameter int               CHANNELS    = 4,
  parameter int               SATURATE    = 0,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [CHANNELS-1:0]       i_inc,
  input  logic [CHANNELS-1:0]       i_dec,
  input  logic [CHANNELS-1:0]       i_load,
  input  logic [CHANNELS*WIDTH-1:0] i_load_value,
  input  logic [CHANNELS-1:0]       i_ovf_clear,
  output logic [CHANNELS*WIDTH-1:0] o_count,
  output logic [CHANNELS-1:0]       o_carry,
  output logic [CHANNELS-1:0]       o_borrow,
  output logic [CHANNELS-1:0]       o_zero,
  output logic [CHANNELS-1:0]       o_full,
  output logic [CHANNELS-1:0]       o_ovf_sticky
);

  localparam bit SatMode = (SATURATE == int'(ModeSat));

  if (WIDTH < CntWidthMin || WIDTH > CntWidthMax) begin : g_bad_width
    $error("common_udcnt_bank: WIDTH out of range");
  end
  if (CHANNELS < CntChanMin || CHANNELS > CntChanMax) begin : g_bad_chan
    $error("common_udcnt_bank: CHANNELS out of range");
  end
  if (SATURATE != int'(ModeWrap) && SATURATE != int'(ModeSat)) begin : g_bad_mode
    $error("common_udcnt_bank: SATURATE must be 0 or 1");
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             borrow_q, borrow_d;
    logic             ovf_q, ovf_d;
    logic             inc_only, dec_only;
    logic [WIDTH-1:0] step_val;
    logic             step_c;

    // inc and dec together cancel out and count as no request.
    assign inc_only = i_inc[k] & ~i_dec[k];
    assign dec_only = i_dec[k] & ~i_inc[k];

    common_decinc_n #(
      .WIDTH(WIDTH)
    ) u_decinc (
      .d  (cnt_q),
      .dec(dec_only),
      .q  (step_val),
      .c  (step_c)
    );

    always_comb begin
      cnt_d    = cnt_q;
      carry_d  = 1'b0;
      borrow_d = 1'b0;
      if (i_load[k]) begin
        cnt_d = i_load_value[k*WIDTH +: WIDTH];
      end else if (inc_only || dec_only) begin
        carry_d  = step_c & inc_only;
        borrow_d = step_c & dec_only;
        // In saturating mode an out-of-range step leaves the count pinned.
        if (!(step_c && SatMode)) begin
          cnt_d = step_val;
        end
      end
      // A new event wins over a simultaneous clear.
      ovf_d = carry_d | borrow_d | (ovf_q & ~i_ovf_clear[k]);
    end

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        cnt_q    <= RESET_VALUE;
        carry_q  <= 1'b0;
        borrow_q <= 1'b0;
        ovf_q    <= 1'b0;
      end else begin
        cnt_q    <= cnt_d;
        carry_q  <= carry_d;
        borrow_q <= borrow_d;
        ovf_q    <= ovf_d;
      end
    end

    assign o_count[k*WIDTH +: WIDTH] = cnt_q;
    assign o_carry[k]                = carry_q;
    assign o_borrow[k]               = borrow_q;
    assign o_ovf_sticky[k]           = ovf_q;
    assign o_zero[k]                 = (cnt_q == '0);
    assign o_full[k]                 = &cnt_q;
  end

endmodule

// File: doc/common_udcnt_bank.md
COMMON_UDCNT_BANK -- requirements
Module: common_udcnt_bank

Interface
REQ-001 Parameter WIDTH, default 2, counter width in bits (1..32).
REQ-002 Parameter CHANNELS, default 4, number of independent counters (1..32).
REQ-003 Parameter SATURATE, default 0; 0 = wrap-around mode, 1 = saturating mode, applies to all channels.
REQ-004 Parameter RESET_VALUE, default 0, WIDTH-bit counter value after reset.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 resetn  input  1  reset, asynchronous, active-low.
REQ-007 i_inc  input  CHANNELS  per-channel increment request.
REQ-008 i_dec  input  CHANNELS  per-channel decrement request.
REQ-009 i_load  input  CHANNELS  per-channel load request.
REQ-010 i_load_value  input  CHANNELS*WIDTH  load data; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-011 i_ovf_clear  input  CHANNELS  per-channel clear of sticky overflow flag.
REQ-012 o_count  output  CHANNELS*WIDTH  registered counter values, same packing as i_load_value.
REQ-013 o_carry  output  CHANNELS  registered one-cycle pulse: increment attempted at all-ones.
REQ-014 o_borrow  output  CHANNELS  registered one-cycle pulse: decrement attempted at zero.
REQ-015 o_zero  output  CHANNELS  count == 0, decoded from o_count.
REQ-016 o_full  output  CHANNELS  count == all-ones, decoded from o_count.
REQ-017 o_ovf_sticky  output  CHANNELS  registered, set by any carry or borrow event, held until cleared.

Function
REQ-018 Channels shall be fully independent; no cross-channel interaction.
REQ-019 Per-channel priority per edge: i_load > (i_inc XOR i_dec) > hold.
REQ-020 i_load=1: count <= load value; carry/borrow <= 0; sticky unaffected except by i_ovf_clear.
REQ-021 i_inc=1, i_dec=1, i_load=0: count holds; carry/borrow <= 0 (net zero change, no event).
REQ-022 Increment below all-ones: count <= count+1, carry <= 0.
REQ-023 Increment at all-ones: carry <= 1; count <= 0 if SATURATE=0, holds all-ones if SATURATE=1.
REQ-024 Decrement above zero: count <= count-1, borrow <= 0.
REQ-025 Decrement at zero: borrow <= 1; count <= all-ones if SATURATE=0, holds 0 if SATURATE=1.
REQ-026 No request: count holds; carry/borrow <= 0, so each pulse is exactly one cycle unless the event repeats.
REQ-027 Latency: o_count, o_carry, o_borrow reflect a request one edge after it is sampled; o_zero/o_full combinational from o_count, no added latency.
REQ-028 Sticky: o_ovf_sticky <= 1 on the edge where carry or borrow is set; else cleared by i_ovf_clear; set wins over simultaneous clear.
REQ-029 Arithmetic is modulo 2^WIDTH; WIDTH=1 shall behave identically (0/1 toggle in wrap mode).
REQ-030 Load of any value, including 0 or all-ones, shall generate no event.

Reset
REQ-031 On resetn low, asynchronously: every count = RESET_VALUE, o_carry = 0, o_borrow = 0, o_ovf_sticky = 0.
REQ-032 Reset mid-operation shall abort all pending requests; first post-reset edge processes current inputs normally.
REQ-033 o_zero/o_full during reset shall follow RESET_VALUE decode.

Structure
REQ-034 Mode encodings (WRAP=0, SAT=1) and width limits shall live in shared package common_cnt_pkg.
REQ-035 Next-value arithmetic shall be in combinational sub-module common_decinc_n (WIDTH parameter; ports d, dec, q, c), one instance per channel; saturation, priority and registers in the top level.
REQ-036 Only clk edge and resetn shall clock state; no latches, no gated clocks.

Verification (WIDTH=2, CHANNELS=4 unless noted)
REQ-037 Reset: drive resetn low mid-count with RESET_VALUE=2 -> all counts 2 immediately, carry/borrow/sticky 0, o_zero=0, o_full=0.
REQ-038 Wrap: ch0 load 3, then inc -> count 0, o_carry pulse one cycle, sticky=1; then dec -> count 3, o_borrow pulse one cycle.
REQ-039 Saturate (SATURATE=1): ch1 at 3, inc three cycles -> count stays 3, o_carry high three cycles, o_full=1; at 0, dec -> stays 0, o_borrow=1.
REQ-040 Simultaneous: ch2 at 1, inc+dec -> holds 1, no pulse; inc+dec+load 3 -> count 3, no pulse.
REQ-041 Sticky: carry event on same edge as i_ovf_clear -> sticky stays 1; next edge clear alone -> sticky 0.
REQ-042 Independence/params: randomised inc/dec/load on all channels with WIDTH=1 and WIDTH=8 -> every channel matches modulo/saturate reference model per cycle.
